// File: rtl/weight_fetch_seq_if.sv
// Bundle of the fetch request, RAM read port and output stream
// used by weight_fetch_seq. The slave modport is the sequencer's view.
interface weight_fetch_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
);
  // fetch request / control
  logic              start;
  logic [4:0]        step;
  logic              range_en;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              abort;
  // RAM read port
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  // output stream
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  // status
  logic [4:0]        step_q;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, step, range_en, first_addr, last_addr, abort, ram_q, out_ready,
    input  ram_re, ram_addr, out_data, out_valid, step_q, busy, done, err
  );

  modport slave (
    input  start, step, range_en, first_addr, last_addr, abort, ram_q, out_ready,
    output ram_re, ram_addr, out_data, out_valid, step_q, busy, done, err
  );
endinterface

// File: rtl/weight_fetch_seq.sv
// Weight fetch sequencer: reads the RAM range [first_addr, last_addr) and
// streams the words through a 2-entry output FIFO with valid/ready flow control.
module weight_fetch_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input logic              clk,
  input logic              rst,
  weight_fetch_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_q;
  logic              inflight;
  logic [1:0]        count;
  logic              rd_ptr, wr_ptr;
  logic [DATA_W-1:0] mem [2];

  logic accept, flush, pop, push, issue_ok, issue, last_issue, drain_done;

  // Handshake and issue-credit decode shared by the FSM and datapath.
  always_comb begin
    accept     = (state == IDLE) && bus.start && bus.range_en;
    flush      = bus.abort && ((state == FETCH) || (state == DRAIN));
    pop        = (count != 2'd0) && bus.out_ready;
    push       = inflight;
    // Words already owned (buffered + in flight) minus the one leaving now
    // must stay below the FIFO depth, so a read never lands in a full FIFO.
    issue_ok   = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    issue      = (state == FETCH) && issue_ok && !bus.abort;
    last_issue = issue && (cur_addr == (last_q - ADDR_ONE));
    // Leave DRAIN together with the final pop so done follows it by one cycle.
    drain_done = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = (bus.last_addr > bus.first_addr) ? FETCH : DONE;
      FETCH: if (bus.abort) state_nxt = IDLE;
             else if (last_issue) state_nxt = DRAIN;
      DRAIN: if (bus.abort) state_nxt = IDLE;
             else if (drain_done) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and registered datapath.
  always_comb begin
    bus.ram_re    = issue;
    bus.ram_addr  = cur_addr;
    bus.busy      = (state == FETCH) || (state == DRAIN);
    bus.done      = (state == DONE);
    bus.out_valid = (count != 2'd0);
    bus.out_data  = mem[rd_ptr];
  end

  // Range bookkeeping: address counter, bounds, step tag and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr   <= '0;
      last_q     <= '0;
      bus.step_q <= '0;
      bus.err    <= 1'b0;
    end else if (accept) begin
      cur_addr   <= bus.first_addr;
      last_q     <= bus.last_addr;
      bus.step_q <= bus.step;
      bus.err    <= (bus.last_addr < bus.first_addr);
    end else if (issue) begin
      cur_addr   <= cur_addr + ADDR_ONE;
    end
  end

  // RAM read pipeline and output FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      // NOTE: the two FIFO words are reset because out_data is read straight
      // from the head entry and must be zero while in reset.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (push) begin
        mem[wr_ptr] <= bus.ram_q;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Directed testbench for weight_fetch_seq with a one-cycle-latency RAM model.
module tb_weight_fetch_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  weight_fetch_seq_if #(.DATA_W(8), .ADDR_W(13)) bus ();

  weight_fetch_seq #(.DATA_W(8), .ADDR_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] word_of(input logic [12:0] a);
    return a[7:0] ^ {a[12:8], 3'b101};
  endfunction

  // RAM: data for the address presented with ram_re appears one cycle later.
  always @(posedge clk or negedge rst) begin
    if (!rst)            bus.ram_q <= 8'h00;
    else if (bus.ram_re) bus.ram_q <= word_of(bus.ram_addr);
  end

  // Results of the last do_fetch run.
  int r_words, r_order_bad, r_issue, r_addr_bad, r_lat_re, r_lat_valid;
  int r_done_cyc, r_last_pop, r_max_occ, r_full_issue;

  // Runs one range; cycle 0 is the cycle start is presented.
  // mode 0: out_ready always 1; mode 1: out_ready 1,0,0,1 repeating.
  // restart_cyc: a second start (other range/step) is presented in that cycle.
  task automatic do_fetch(input logic [12:0] f, input logic [12:0] l,
                          input logic [4:0] s, input int mode, input int restart_cyc);
    int          occ;
    bit          pop_now;
    logic [12:0] exp_a;
    r_words = 0; r_order_bad = 0; r_issue = 0; r_addr_bad = 0; r_lat_re = -1;
    r_lat_valid = -1; r_done_cyc = -1; r_last_pop = -1; r_max_occ = 0; r_full_issue = 0;
    occ = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      bus.start    = (cyc == 0) || (cyc == restart_cyc);
      bus.range_en = bus.start;
      if (cyc == restart_cyc) begin
        bus.first_addr = 13'd1000; bus.last_addr = 13'd1002; bus.step = 5'd31;
      end else begin
        bus.first_addr = f; bus.last_addr = l; bus.step = s;
      end
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge clk);
      if (occ > r_max_occ) r_max_occ = occ;
      pop_now = bus.out_valid && bus.out_ready;
      if (bus.ram_re) begin
        exp_a = f + 13'(r_issue);
        if (r_issue == 0) r_lat_re = cyc;
        if (bus.ram_addr !== exp_a) r_addr_bad++;
        if (occ >= 2 && !pop_now) r_full_issue++;
        r_issue++; occ++;
      end
      if (bus.out_valid && r_lat_valid < 0) r_lat_valid = cyc;
      if (pop_now) begin
        exp_a = f + 13'(r_words);
        if (bus.out_data !== word_of(exp_a)) r_order_bad++;
        r_words++; occ--; r_last_pop = cyc;
      end
      if (bus.done) begin
        r_done_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.range_en = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    bus.start = 0; bus.step = 0; bus.range_en = 0; bus.first_addr = 0;
    bus.last_addr = 0; bus.abort = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    tests++; if (bus.ram_re !== 1'b0) begin fails++; $display("FAIL reset_ram_re: got %b want 0", bus.ram_re); end
    tests++; if (bus.ram_addr !== 13'd0) begin fails++; $display("FAIL reset_ram_addr: got %0d want 0", bus.ram_addr); end
    tests++; if ({bus.out_valid, bus.busy, bus.done, bus.err} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {bus.out_valid, bus.busy, bus.done, bus.err}); end
    tests++; if ({bus.out_data, bus.step_q} !== 13'd0) begin fails++; $display("FAIL reset_data_step: got %h want 0", {bus.out_data, bus.step_q}); end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_basic;
    do_fetch(13'd784, 13'd788, 5'd2, 0, -1);
    tests++; if (r_issue !== 4 || r_addr_bad !== 0) begin fails++; $display("FAIL basic_issue: got %0d reads %0d bad want 4 reads 0 bad", r_issue, r_addr_bad); end
    tests++; if (r_lat_re !== 1 || r_lat_valid !== 3) begin fails++; $display("FAIL basic_latency: got re@%0d valid@%0d want re@1 valid@3", r_lat_re, r_lat_valid); end
    tests++; if (r_words !== 4 || r_order_bad !== 0) begin fails++; $display("FAIL basic_words: got %0d words %0d bad want 4 words 0 bad", r_words, r_order_bad); end
    tests++; if (r_done_cyc !== 7 || r_last_pop !== 6) begin fails++; $display("FAIL basic_done: got done@%0d lastpop@%0d want done@7 lastpop@6", r_done_cyc, r_last_pop); end
    tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    tests++; if (bus.step_q !== 5'd2 || bus.err !== 1'b0) begin fails++; $display("FAIL basic_step_err: got step_q=%0d err=%b want 2 0", bus.step_q, bus.err); end
  endtask

  task automatic test_backpressure;
    do_fetch(13'd0, 13'd6, 5'd5, 1, -1);
    tests++; if (r_words !== 6 || r_order_bad !== 0) begin fails++; $display("FAIL bp_words: got %0d words %0d bad want 6 words 0 bad", r_words, r_order_bad); end
    tests++; if (r_issue !== 6 || r_addr_bad !== 0) begin fails++; $display("FAIL bp_issue: got %0d reads %0d bad want 6 reads 0 bad", r_issue, r_addr_bad); end
    tests++; if (r_max_occ > 2 || r_full_issue !== 0) begin fails++; $display("FAIL bp_occupancy: got max %0d full-issues %0d want <=2 and 0", r_max_occ, r_full_issue); end
    tests++; if (r_done_cyc < 0 || r_done_cyc !== r_last_pop + 1) begin fails++; $display("FAIL bp_done: got done@%0d lastpop@%0d want done one cycle after last pop", r_done_cyc, r_last_pop); end
  endtask

  task automatic test_empty_ranges;
    do_fetch(13'd100, 13'd100, 5'd3, 0, -1);
    tests++; if (r_issue !== 0 || r_done_cyc !== 1) begin fails++; $display("FAIL equal_range: got %0d reads done@%0d want 0 reads done@1", r_issue, r_done_cyc); end
    tests++; if (bus.err !== 1'b0 || bus.step_q !== 5'd3) begin fails++; $display("FAIL equal_err: got err=%b step_q=%0d want 0 3", bus.err, bus.step_q); end
    do_fetch(13'd50, 13'd40, 5'd4, 0, -1);
    tests++; if (r_issue !== 0 || r_words !== 0 || r_done_cyc !== 1) begin fails++; $display("FAIL reversed_range: got %0d reads %0d words done@%0d want 0 0 done@1", r_issue, r_words, r_done_cyc); end
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL reversed_err: got err=%b want 1", bus.err); end
  endtask

  task automatic test_top_addr;
    do_fetch(13'd8189, 13'd8191, 5'd6, 0, -1);
    tests++; if (r_words !== 2 || r_order_bad !== 0 || r_addr_bad !== 0) begin fails++; $display("FAIL top_words: got %0d words %0d/%0d bad want 2 0/0", r_words, r_order_bad, r_addr_bad); end
    tests++; if (r_done_cyc !== r_last_pop + 1 || bus.busy !== 1'b0 || bus.ram_re !== 1'b0) begin fails++; $display("FAIL top_end: got done@%0d lastpop@%0d busy=%b re=%b want done after pop, idle", r_done_cyc, r_last_pop, bus.busy, bus.ram_re); end
  endtask

  task automatic test_abort;
    int issued, late_re, late_done, abort_cyc;
    issued = 0; late_re = 0; late_done = 0; abort_cyc = -1;
    for (int cyc = 0; cyc < 40 && abort_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      bus.start = (cyc == 0); bus.range_en = (cyc == 0);
      bus.first_addr = 13'd200; bus.last_addr = 13'd210; bus.step = 5'd8;
      bus.out_ready = 1'b1;
      if (issued == 3) begin bus.abort = 1'b1; abort_cyc = cyc; end
      @(negedge clk);
      if (bus.ram_re && abort_cyc < 0) issued++;
    end
    @(posedge clk); #1; bus.abort = 1'b0;
    @(negedge clk);
    tests++; if (abort_cyc < 0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL abort_idle: got abort@%0d busy=%b valid=%b done=%b want aborted, 0 0 0", abort_cyc, bus.busy, bus.out_valid, bus.done); end
    repeat (6) begin
      @(negedge clk);
      if (bus.ram_re) late_re++;
      if (bus.done) late_done++;
    end
    tests++; if (late_re !== 0 || late_done !== 0) begin fails++; $display("FAIL abort_quiet: got %0d reads %0d done pulses want 0 0", late_re, late_done); end
    do_fetch(13'd300, 13'd305, 5'd9, 0, -1);
    tests++; if (r_words !== 5 || r_order_bad !== 0 || r_done_cyc !== 8) begin fails++; $display("FAIL abort_refetch: got %0d words %0d bad done@%0d want 5 0 done@8", r_words, r_order_bad, r_done_cyc); end
  endtask

  task automatic test_reset_mid;
    int stray;
    stray = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      bus.start = (cyc == 0); bus.range_en = (cyc == 0);
      bus.first_addr = 13'd400; bus.last_addr = 13'd420; bus.step = 5'd12;
      bus.out_ready = 1'b0;
      @(negedge clk);
    end
    tests++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL rstmid_pre: got valid=%b busy=%b want 1 1", bus.out_valid, bus.busy); end
    @(posedge clk); #1; rst = 1'b0; #1;
    tests++; if ({bus.ram_re, bus.out_valid, bus.busy, bus.done, bus.err} !== 5'b0 || bus.ram_addr !== 13'd0 || bus.out_data !== 8'd0 || bus.step_q !== 5'd0) begin fails++; $display("FAIL rstmid_outputs: got re=%b valid=%b busy=%b done=%b err=%b addr=%0d data=%0d step_q=%0d want all 0", bus.ram_re, bus.out_valid, bus.busy, bus.done, bus.err, bus.ram_addr, bus.out_data, bus.step_q); end
    bus.start = 1'b1; bus.range_en = 1'b1; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1; bus.start = 1'b0; bus.range_en = 1'b0; rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.ram_re || bus.out_valid || bus.done) stray++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL rstmid_after: got %0d active cycles want 0", stray); end
    do_fetch(13'd500, 13'd503, 5'd13, 0, -1);
    tests++; if (r_words !== 3 || r_order_bad !== 0 || bus.step_q !== 5'd13) begin fails++; $display("FAIL rstmid_refetch: got %0d words %0d bad step_q=%0d want 3 0 13", r_words, r_order_bad, bus.step_q); end
  endtask

  task automatic test_ignored;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.range_en = 1'b0; bus.step = 5'd9;
    bus.first_addr = 13'd1; bus.last_addr = 13'd5;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ram_re !== 1'b0 || bus.step_q !== 5'd13) begin fails++; $display("FAIL no_range_en: got busy=%b done=%b re=%b step_q=%0d want 0 0 0 13", bus.busy, bus.done, bus.ram_re, bus.step_q); end
    do_fetch(13'd600, 13'd606, 5'd7, 0, 2);
    tests++; if (r_words !== 6 || r_order_bad !== 0 || r_issue !== 6 || r_addr_bad !== 0) begin fails++; $display("FAIL busy_start_words: got %0d words %0d bad %0d reads %0d bad want 6 0 6 0", r_words, r_order_bad, r_issue, r_addr_bad); end
    tests++; if (bus.step_q !== 5'd7 || r_done_cyc !== 9) begin fails++; $display("FAIL busy_start_step: got step_q=%0d done@%0d want 7 done@9", bus.step_q, r_done_cyc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_ranges();
    test_top_addr();
    test_abort();
    test_reset_mid();
    test_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
